regfile_scoreboard: RTL and testbench
=====================================

// Module: regfile_scoreboard
// PURPOSE
//  Integer register file that consumes the write-back port (regf_write/waddr/wdata) and
//  serves the two decode-stage operand reads. Write-first bypass: a value retiring this cycle
//  is visible to readers in the same cycle. Per-register pending-write scoreboard: decode marks rd
//  on issue, write-back retires it, and a busy flag tells hazard logic to stall.
//  Sits between decode (read/issue side) and write_back (write side).
// PARAMETERS
//  NREGS     32  number of architectural registers; x0 hardwired to zero.
//  PEND_W    2   width of per-register pending-write counter; max in-flight = 2**PEND_W-1.
//  RESET_RF  1   1: storage cleared to 0 on reset; 0: storage not reset, only the scoreboard.
// PORTS
//  clk_i          in   1   clock, rising edge
//  rstn_i         in   1   asynchronous active-low reset
//  regf_write_i   in   1   write-back write enable
//  regf_waddr_i   in   5   write-back destination register
//  regf_wdata_i   in   32  write-back data
//  rs1_addr_i     in   5   operand 1 read address
//  rs2_addr_i     in   5   operand 2 read address
//  rs1_rdata_o    out  32  operand 1 data (combinational)
//  rs2_rdata_o    out  32  operand 2 data (combinational)
//  rs1_busy_o     out  1   operand 1 has an un-retired write pending
//  rs2_busy_o     out  1   operand 2 has an un-retired write pending
//  issue_i        in   1   decode issues an instruction that writes rd
//  issue_rd_i     in   5   destination of issued instruction
//  issue_ready_o  out  1   0 = counter of issue_rd_i saturated; issue_i must not be asserted
//  flush_i        in   1   pipeline flush: clear every pending counter
// BEHAVIOUR
//  Reset (async, rstn_i=0): all pending counters=0; storage=0 if RESET_RF. Outputs follow:
//   rdata = 0 (RESET_RF=1), busy_o = 0, issue_ready_o = 1.
//  Write: on posedge, when regf_write_i && regf_waddr_i != 0, write mem[waddr] <= wdata.
//   Writes to x0 are dropped.
//  Read (0-cycle latency): rsN_rdata_o = 0 if rsN_addr_i == 0;
//   else regf_wdata_i if regf_write_i && regf_waddr_i == rsN_addr_i (bypass);
//   else mem[rsN_addr_i].
//  Pending counter cnt[r], r != 0, updated each posedge:
//   inc = issue_i && issue_rd_i == r. dec = regf_write_i && regf_waddr_i == r && cnt[r] != 0.
//   inc & !dec: +1. dec & !inc: -1. both or neither: unchanged.
//   dec with cnt[r] == 0 (untracked write, e.g. CSR/load replay): data written, cnt stays 0.
//   cnt[0] is always 0; issue to x0 is ignored.
//  flush_i: all cnt <= 0 next edge, overriding same-cycle inc/dec. Same-cycle data write still occurs.
//  busy: rsN_busy_o = (rsN_addr_i != 0) && cnt[rsN] != 0 && !(dec_this_cycle && cnt[rsN] == 1).
//   A last pending write retiring this cycle is satisfied by the bypass.
//  issue_ready_o = (issue_rd_i == 0) || cnt[issue_rd_i] != 2**PEND_W-1 || dec on issue_rd_i.
//   issue_i while !issue_ready_o is a protocol error: assertion fires, counter saturates (no wrap).
//  Reset mid-operation clears the scoreboard immediately. In-flight write-back data arriving after
//   reset is written but not tracked.
// TESTING
//  1 Reset, read x1..x31 -> rdata 0, busy 0, issue_ready 1.
//    Write x5=0xDEADBEEF, read next cycle -> 0xDEADBEEF.
//  2 Write x0=0x1234 while rs1=x0 -> rs1_rdata 0 same and next cycle.
//    issue rd=x0 -> rs1_busy 0.
//  3 Write x7=0xA5A5A5A5 with rs1=rs2=x7 same cycle -> both rdata 0xA5A5A5A5 (bypass), before mem update.
//  4 Issue x3 twice (cnt=2) -> rs1_busy 1. One WB -> busy 1.
//    Second WB -> busy 0 in the WB cycle itself, rdata = WB data.
//  5 Issue x9 x3 (cnt=3, PEND_W=2) -> issue_ready 0 for rd=x9.
//    Same cycle WB x9 -> issue_ready 1. Simultaneous issue+WB keeps cnt=3.
//  6 Issue x4,x8, assert flush_i with WB x4 -> all busy 0 next cycle, mem[x4] updated.
//    Async reset mid-burst -> busy drops without clock.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// Integer register file with write-first bypass and a per-register pending-write scoreboard.
// Decode reads operands and marks destinations on issue; write-back retires them.
module regfile_scoreboard #(
    parameter int unsigned NREGS    = 32,
    parameter int unsigned PEND_W   = 2,
    parameter int unsigned RESET_RF = 1
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,

    input  logic                        regf_write_i,
    input  logic [$clog2(NREGS)-1:0]    regf_waddr_i,
    input  logic [31:0]                 regf_wdata_i,

    input  logic [$clog2(NREGS)-1:0]    rs1_addr_i,
    input  logic [$clog2(NREGS)-1:0]    rs2_addr_i,
    output logic [31:0]                 rs1_rdata_o,
    output logic [31:0]                 rs2_rdata_o,
    output logic                        rs1_busy_o,
    output logic                        rs2_busy_o,

    input  logic                        issue_i,
    input  logic [$clog2(NREGS)-1:0]    issue_rd_i,
    output logic                        issue_ready_o,

    input  logic                        flush_i
);

    localparam int unsigned AW   = $clog2(NREGS);
    localparam int unsigned XLEN = 32;
    localparam logic [PEND_W-1:0] CNT_MAX = {PEND_W{1'b1}};
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [XLEN-1:0]   mem_q [NREGS];
    logic [PEND_W-1:0] cnt_q [NREGS];
    logic [PEND_W-1:0] cnt_d [NREGS];

    logic [NREGS-1:0]  inc_c;
    logic [NREGS-1:0]  dec_c;
    logic              wr_en_c;

    assign wr_en_c = regf_write_i && (regf_waddr_i != '0);

    // Per-register issue (inc) and retire (dec) strobes; untracked writes never decrement.
    always_comb begin
        inc_c = '0;
        dec_c = '0;
        for (int unsigned r = 1; r < NREGS; r++) begin
            inc_c[r] = issue_i && (issue_rd_i == AW'(r));
            dec_c[r] = regf_write_i && (regf_waddr_i == AW'(r)) && (cnt_q[r] != '0);
        end
    end

    // Pending counter next state; flush overrides inc/dec, saturation never wraps.
    always_comb begin
        for (int unsigned r = 0; r < NREGS; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        for (int unsigned r = 1; r < NREGS; r++) begin
            if (flush_i) begin
                cnt_d[r] = '0;
            end else if (inc_c[r] && !dec_c[r]) begin
                if (cnt_q[r] != CNT_MAX) begin
                    cnt_d[r] = cnt_q[r] + CNT_ONE;
                end
            end else if (dec_c[r] && !inc_c[r]) begin
                cnt_d[r] = cnt_q[r] - CNT_ONE;
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Storage: optionally cleared on reset; x0 writes are dropped.
    if (RESET_RF != 0) begin : g_rf_rst
        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                for (int unsigned r = 0; r < NREGS; r++) begin
                    mem_q[r] <= '0;
                end
            end else if (wr_en_c) begin
                mem_q[regf_waddr_i] <= regf_wdata_i;
            end
        end
    end else begin : g_rf_norst
        always_ff @(posedge clk_i) begin
            if (wr_en_c) begin
                mem_q[regf_waddr_i] <= regf_wdata_i;
            end
        end
    end

    // Operand reads: x0 is zero, a same-cycle retiring write wins over storage.
    assign rs1_rdata_o = (rs1_addr_i == '0) ? '0 :
                         (regf_write_i && (regf_waddr_i == rs1_addr_i)) ? regf_wdata_i :
                         mem_q[rs1_addr_i];
    assign rs2_rdata_o = (rs2_addr_i == '0) ? '0 :
                         (regf_write_i && (regf_waddr_i == rs2_addr_i)) ? regf_wdata_i :
                         mem_q[rs2_addr_i];

    // A last pending write retiring this cycle is covered by the bypass, so it is not busy.
    assign rs1_busy_o = (rs1_addr_i != '0) && (cnt_q[rs1_addr_i] != '0) &&
                        !(dec_c[rs1_addr_i] && (cnt_q[rs1_addr_i] == CNT_ONE));
    assign rs2_busy_o = (rs2_addr_i != '0) && (cnt_q[rs2_addr_i] != '0) &&
                        !(dec_c[rs2_addr_i] && (cnt_q[rs2_addr_i] == CNT_ONE));

    assign issue_ready_o = (issue_rd_i == '0) || (cnt_q[issue_rd_i] != CNT_MAX) ||
                           dec_c[issue_rd_i];

    a_issue_not_saturated : assert property (
        @(posedge clk_i) disable iff (!rstn_i) issue_i |-> issue_ready_o
    ) else $error("issue_i asserted while pending counter of issue_rd_i is saturated");

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized scoreboard bench for regfile_scoreboard against an array/integer reference model.
module tb_regfile_scoreboard;

    localparam int NREGS = 32;
    localparam int MAXP  = 3;

    logic        clk;
    logic        rstn_i;
    logic        regf_write_i;
    logic [4:0]  regf_waddr_i;
    logic [31:0] regf_wdata_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i;
    logic [31:0] rs1_rdata_o, rs2_rdata_o;
    logic        rs1_busy_o, rs2_busy_o;
    logic        issue_i;
    logic [4:0]  issue_rd_i;
    logic        issue_ready_o;
    logic        flush_i;

    regfile_scoreboard #(.NREGS(32), .PEND_W(2), .RESET_RF(1)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn_i),
        .regf_write_i (regf_write_i),
        .regf_waddr_i (regf_waddr_i),
        .regf_wdata_i (regf_wdata_i),
        .rs1_addr_i   (rs1_addr_i),
        .rs2_addr_i   (rs2_addr_i),
        .rs1_rdata_o  (rs1_rdata_o),
        .rs2_rdata_o  (rs2_rdata_o),
        .rs1_busy_o   (rs1_busy_o),
        .rs2_busy_o   (rs2_busy_o),
        .issue_i      (issue_i),
        .issue_rd_i   (issue_rd_i),
        .issue_ready_o(issue_ready_o),
        .flush_i      (flush_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic        b1;
        logic        b2;
        logic        rdy;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model: architectural contents plus outstanding-write count per register.
    logic [31:0] m_mem [NREGS];
    int          m_cnt [NREGS];

    function automatic void m_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_mem[r] = 32'h0;
            m_cnt[r] = 0;
        end
    endfunction

    function automatic bit m_retires(input logic we, input logic [4:0] wa, input int r);
        return we && (int'(wa) == r) && (r != 0) && (m_cnt[r] > 0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a, input logic we,
                                           input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'h0;
        if (we && wa == a) return wd;
        return m_mem[int'(a)];
    endfunction

    function automatic logic m_busy(input logic [4:0] a, input logic we, input logic [4:0] wa);
        int r;
        r = int'(a);
        if (r == 0 || m_cnt[r] == 0) return 1'b0;
        if (m_retires(we, wa, r) && m_cnt[r] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_ready(input logic [4:0] rd, input logic we, input logic [4:0] wa);
        int r;
        r = int'(rd);
        return (r == 0) || (m_cnt[r] < MAXP) || m_retires(we, wa, r);
    endfunction

    function automatic void m_update(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                     input logic iss, input logic [4:0] ird, input logic fl);
        int nc [NREGS];
        for (int r = 0; r < NREGS; r++) begin
            nc[r] = m_cnt[r];
            if (r != 0) begin
                if (iss && int'(ird) == r) nc[r] = nc[r] + 1;
                if (m_retires(we, wa, r))   nc[r] = nc[r] - 1;
                if (nc[r] > MAXP) nc[r] = MAXP;
            end
            if (fl) nc[r] = 0;
        end
        for (int r = 0; r < NREGS; r++) m_cnt[r] = nc[r];
        if (we && wa != 5'd0) m_mem[int'(wa)] = wd;
    endfunction

    // One cycle of stimulus: drive after the edge, queue the expected combinational response.
    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] a1, input logic [4:0] a2,
                        input logic iss, input logic [4:0] ird,
                        input logic fl, input logic arst);
        exp_t e;
        @(posedge clk);
        #1;
        rstn_i       = 1'b1;
        regf_write_i = we;
        regf_waddr_i = wa;
        regf_wdata_i = wd;
        rs1_addr_i   = a1;
        rs2_addr_i   = a2;
        issue_i      = iss;
        issue_rd_i   = ird;
        flush_i      = fl;
        if (arst) begin
            rstn_i = 1'b0;
            m_reset();
        end
        e.r1  = m_read(a1, we, wa, wd);
        e.r2  = m_read(a2, we, wa, wd);
        e.b1  = m_busy(a1, we, wa);
        e.b2  = m_busy(a2, we, wa);
        e.rdy = m_ready(ird, we, wa);
        exp_q.push_back(e);
        if (!arst) m_update(we, wa, wd, iss, ird, fl);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: outputs are settled mid-cycle, compare on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rs1_rdata",   rs1_rdata_o,           e.r1);
            chk("rs2_rdata",   rs2_rdata_o,           e.r2);
            chk("rs1_busy",    32'(rs1_busy_o),       32'(e.b1));
            chk("rs2_busy",    32'(rs2_busy_o),       32'(e.b2));
            chk("issue_ready", 32'(issue_ready_o),    32'(e.rdy));
        end
    end

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 7) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 9));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we, iss, fl, ar;
        logic [4:0]  wa, a1, a2, ird;
        logic [31:0] wd;

        m_reset();
        rstn_i = 1'b0;
        regf_write_i = 1'b0; regf_waddr_i = '0; regf_wdata_i = '0;
        rs1_addr_i = '0; rs2_addr_i = '0;
        issue_i = 1'b0; issue_rd_i = '0; flush_i = 1'b0;
        repeat (3) @(posedge clk);

        // Reset state of every register
        for (int i = 1; i < 32; i++) step(0, 0, 0, 5'(i), 5'(32 - i), 0, 5'(i), 0, 0);
        step(1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd1, 0, 0, 0, 0);
        step(0, 0, 0, 5'd5, 5'd5, 0, 0, 0, 0);

        // x0 is immutable and untracked
        step(1, 5'd0, 32'h1234, 5'd0, 5'd0, 0, 0, 0, 0);
        step(0, 0, 0, 5'd0, 5'd0, 1, 5'd0, 0, 0);
        step(0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0);

        // Bypass on both ports
        step(1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 0, 0, 0, 0);
        step(0, 0, 0, 5'd7, 5'd7, 0, 0, 0, 0);

        // Two in flight on x3, retire one at a time
        step(0, 0, 0, 5'd3, 5'd3, 1, 5'd3, 0, 0);
        step(0, 0, 0, 5'd3, 5'd3, 1, 5'd3, 0, 0);
        step(0, 0, 0, 5'd3, 5'd3, 0, 5'd3, 0, 0);
        step(1, 5'd3, 32'h11111111, 5'd3, 5'd0, 0, 0, 0, 0);
        step(1, 5'd3, 32'h22222222, 5'd3, 5'd3, 0, 0, 0, 0);
        step(0, 0, 0, 5'd3, 5'd3, 0, 0, 0, 0);

        // Saturation on x9 and simultaneous issue + retire
        for (int i = 0; i < 3; i++) step(0, 0, 0, 5'd9, 0, 1, 5'd9, 0, 0);
        step(0, 0, 0, 5'd9, 0, 0, 5'd9, 0, 0);
        step(1, 5'd9, 32'h99, 5'd9, 0, 1, 5'd9, 0, 0);
        step(0, 0, 0, 5'd9, 0, 0, 5'd9, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 5'd9, 32'(i), 5'd9, 0, 0, 5'd9, 0, 0);
        step(0, 0, 0, 5'd9, 0, 0, 5'd9, 0, 0);

        // Flush with same-cycle write-back, then async reset with pending writes
        step(0, 0, 0, 5'd4, 5'd8, 1, 5'd4, 0, 0);
        step(0, 0, 0, 5'd4, 5'd8, 1, 5'd8, 0, 0);
        step(1, 5'd4, 32'hCAFE0004, 5'd4, 5'd8, 0, 0, 1, 0);
        step(0, 0, 0, 5'd4, 5'd8, 0, 0, 0, 0);
        step(0, 0, 0, 5'd4, 5'd8, 1, 5'd4, 0, 0);
        step(0, 0, 0, 5'd4, 5'd8, 1, 5'd8, 0, 0);
        step(0, 0, 0, 5'd4, 5'd8, 0, 0, 0, 1);
        step(1, 5'd4, 32'h0BAD0004, 5'd4, 5'd8, 0, 5'd4, 0, 0);
        step(0, 0, 0, 5'd4, 5'd8, 0, 5'd4, 0, 0);

        // Randomized traffic on a small hot register set
        for (int n = 0; n < 1500; n++) begin
            we  = 1'($urandom_range(0, 1));
            wa  = rnd_addr();
            wd  = $urandom;
            a1  = ($urandom_range(0, 3) == 0) ? wa : rnd_addr();
            a2  = rnd_addr();
            ird = rnd_addr();
            fl  = ($urandom_range(0, 39) == 0);
            ar  = ($urandom_range(0, 299) == 0);
            iss = 1'($urandom_range(0, 1)) && m_ready(ird, we, wa);
            step(we, wa, wd, a1, a2, iss, ird, fl, ar);
        end

        @(posedge clk);
        #1;
        regf_write_i = 1'b0; issue_i = 1'b0; flush_i = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
